seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 7, operand/result width in bits.
REQ-002 Parameter AMT_W, default 3, width of the rotate-amount field taken from b[AMT_W-1:0].
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  controller presents a, b, op this cycle.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B / rotate amount.
REQ-009 op  input  3  operation code.
REQ-010 rsp_valid  output  1  result and flag are valid.
REQ-011 rsp_ready  input  1  controller consumes the response this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flag  output  1  status flag for result.
REQ-014 ops_done  output  8  count of completed responses, wraps 255->0.

Function
REQ-015 Op codes: 0 NOT a; 1 rotate-right a by b[AMT_W-1:0]; 2 NOP (result 0); 3 a AND b; 4 a OR b; 5 a XOR b; 6 a+b mod 2^WIDTH; 7 rotate-left a by b[AMT_W-1:0].
REQ-016 flag = carry-out for op 6; flag = (result==0) for all other ops.
REQ-017 FSM states IDLE, EXEC, RESP; req_ready = 1 only in IDLE.
REQ-018 Accept when req_valid && req_ready at edge N; a, b, op registered at edge N; inputs ignored in all other cycles.
REQ-019 Ops 0,2-6: IDLE->RESP at edge N; rsp_valid high in cycle N+1.
REQ-020 Ops 1,7: IDLE->EXEC at edge N, counter loaded with amount; each EXEC edge with counter!=0 rotates accumulator by one bit and decrements; EXEC edge with counter==0 goes to RESP; rsp_valid high in cycle N+2+amount.
REQ-021 Amount 0 returns a unchanged; amount equal to WIDTH returns a unchanged; amounts above WIDTH rotate amount mod WIDTH equivalently (one bit per cycle, no shortcut).
REQ-022 result/flag held stable while rsp_valid && !rsp_ready; RESP->IDLE at the edge where rsp_ready is high; ops_done increments on that edge.
REQ-023 No request accepted in the cycle the response is consumed; earliest next accept is the following cycle (req_ready high one cycle after handshake).
REQ-024 result and flag are registered outputs; no combinational path from inputs to rsp_valid, result or flag.

Reset
REQ-025 reset forces IDLE; req_ready=1, rsp_valid=0, result=0, flag=0, ops_done=0, counter=0 asynchronously.
REQ-026 reset during EXEC or RESP abandons the operation; no response is issued and ops_done does not increment.

Configuration
REQ-027 Macro SEQ_ALU_FAST_ROT_EN defined: ops 1 and 7 computed by a single-cycle barrel rotator, follow REQ-019 timing, EXEC state unused.
REQ-028 Macro SEQ_ALU_FAST_ROT_EN undefined: ops 1 and 7 iterative per REQ-020; all other behaviour identical.

Structure
REQ-029 Package seq_alu_pkg holds op-code constants, the state enum, and WIDTH/AMT_W defaults.
REQ-030 Sub-module seq_alu_rot: one-bit rotate step (direction input); instantiated in iterative mode only.

Verification
REQ-031 Reset, then op=0 a=0101010 -> cycle N+1 result=1010101, flag=0.
REQ-032 op=1 a=0001101 b=0000011 -> rsp_valid in cycle N+5 (N+1 with SEQ_ALU_FAST_ROT_EN), result=1010001, flag=0.
REQ-033 op=2 a=any -> result=0000000, flag=1; op=6 a=1111111 b=0000001 -> result=0000000, flag=1.
REQ-034 rsp_ready held low 4 cycles after rsp_valid -> result/flag stable, req_ready=0, req_valid ignored; ops_done increments once on release.
REQ-035 reset asserted mid-rotate (op=7, amount 5, 2 cycles in) -> IDLE next cycle, rsp_valid=0, ops_done unchanged; fresh op=0 request then completes normally.
REQ-036 256 back-to-back op=3 transactions -> ops_done wraps to 0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: default widths, op-code constants and FSM state type.
package seq_alu_pkg;

    localparam int WIDTH_DEF = 7;
    localparam int AMT_W_DEF = 3;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_NOP = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_ADD = 3'd6;
    localparam logic [2:0] OP_ROL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_rot.sv
// One-bit rotate step; left=1 rotates toward the MSB, left=0 toward the LSB.
module seq_alu_rot
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] din,
    input  logic             left,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        if (left) dout = {din[WIDTH-2:0], din[WIDTH-1]};
        else      dout = {din[0], din[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready request and response handshakes.
// Define SEQ_ALU_FAST_ROT_EN for single-cycle barrel rotates instead of iterative ones.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic [7:0]       ops_done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_flag;
    logic             is_rot;

    assign is_rot    = (op == OP_ROR) || (op == OP_ROL);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

`ifdef SEQ_ALU_FAST_ROT_EN
    // Rotation by a power-of-two stage is reduced mod WIDTH, so any amount wraps correctly.
    function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v,
                                                input logic [AMT_W-1:0] n,
                                                input logic left);
        logic [WIDTH-1:0] r;
        int unsigned      k;
        r = v;
        for (int unsigned i = 0; i < AMT_W; i++) begin
            k = (32'd1 << i) % 32'(WIDTH);
            if (n[i] && (k != 0)) begin
                if (left) r = (r << k) | (r >> (32'(WIDTH) - k));
                else      r = (r >> k) | (r << (32'(WIDTH) - k));
            end
        end
        return r;
    endfunction
`else
    logic [WIDTH-1:0] acc, acc_step;
    logic [AMT_W-1:0] cnt;
    logic             dir_left;

    seq_alu_rot #(.WIDTH(WIDTH)) u_rot (
        .din  (acc),
        .left (dir_left),
        .dout (acc_step)
    );
`endif

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op)
            OP_NOT: alu_res = ~a;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD: {alu_cy, alu_res} = {1'b0, a} + {1'b0, b};
`ifdef SEQ_ALU_FAST_ROT_EN
            OP_ROR: alu_res = barrel(a, b[AMT_W-1:0], 1'b0);
            OP_ROL: alu_res = barrel(a, b[AMT_W-1:0], 1'b1);
`endif
            default: alu_res = '0;
        endcase
        alu_flag = (op == OP_ADD) ? alu_cy : (alu_res == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef SEQ_ALU_FAST_ROT_EN
                    state_nxt = RESP;
`else
                    state_nxt = is_rot ? EXEC : RESP;
`endif
                end
            end
`ifndef SEQ_ALU_FAST_ROT_EN
            EXEC: if (cnt == '0) state_nxt = RESP;
`endif
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            flag     <= 1'b0;
            ops_done <= '0;
`ifndef SEQ_ALU_FAST_ROT_EN
            acc      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
`ifdef SEQ_ALU_FAST_ROT_EN
                        result <= alu_res;
                        flag   <= alu_flag;
`else
                        if (is_rot) begin
                            acc      <= a;
                            cnt      <= b[AMT_W-1:0];
                            dir_left <= (op == OP_ROL);
                        end else begin
                            result <= alu_res;
                            flag   <= alu_flag;
                        end
`endif
                    end
                end
`ifndef SEQ_ALU_FAST_ROT_EN
                EXEC: begin
                    if (cnt != '0) begin
                        acc <= acc_step;
                        cnt <= cnt - AMT_W'(1);
                    end else begin
                        result <= acc;
                        flag   <= (acc == '0);
                    end
                end
`endif
                RESP: if (rsp_ready) ops_done <= ops_done + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=7, AMT_W=3); honours SEQ_ALU_FAST_ROT_EN.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] a = '0;
    logic [6:0] b = '0;
    logic [2:0] op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [6:0] result;
    logic       flag;
    logic [7:0] ops_done;

    int total = 0;
    int bad = 0;

    seq_alu #(.WIDTH(7), .AMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .flag      (flag),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rot_lat(input int amt);
`ifdef SEQ_ALU_FAST_ROT_EN
        return 1;
`else
        return 2 + amt;
`endif
    endfunction

    // Present one request and return just after the accepting edge, scrambling inputs afterwards.
    task automatic issue(input logic [2:0] o, input logic [6:0] va, input logic [6:0] vb);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_val("req_ready_timeout", 32'(req_ready), 32'd1);
        op = o; a = va; b = vb; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = 7'($urandom); b = 7'($urandom); op = 3'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) check_val("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [6:0] va,
                          input logic [6:0] vb, input logic [6:0] er, input logic ef, input int el);
        int lat;
        logic [7:0] cnt0;
        cnt0 = ops_done;
        issue(o, va, vb);
        wait_rsp(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(el));
        check_val({tag, "_res"}, 32'(result), 32'(er));
        check_val({tag, "_flag"}, 32'(flag), 32'(ef));
        check_val({tag, "_rdy_busy"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
        check_val({tag, "_cnt"}, 32'(ops_done), 32'(cnt0 + 8'd1));
    endtask

    initial begin
        int n;
        logic [7:0] cnt0;

        #12;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_flag", 32'(flag), 32'd0);
        check_val("rst_ops_done", 32'(ops_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("not",     3'd0, 7'b0101010, 7'b0000000, 7'b1010101, 1'b0, 1);
        run_op("ror3",    3'd1, 7'b0001101, 7'b0000011, 7'b1010001, 1'b0, rot_lat(3));
        run_op("nop",     3'd2, 7'b1100110, 7'b0110011, 7'b0000000, 1'b1, 1);
        run_op("add_cy",  3'd6, 7'b1111111, 7'b0000001, 7'b0000000, 1'b1, 1);
        run_op("add",     3'd6, 7'b0000011, 7'b0000100, 7'b0000111, 1'b0, 1);
        run_op("and",     3'd3, 7'b1100110, 7'b1010101, 7'b1000100, 1'b0, 1);
        run_op("or_zero", 3'd4, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 1);
        run_op("or",      3'd4, 7'b1000000, 7'b0000101, 7'b1000101, 1'b0, 1);
        run_op("xor_z",   3'd5, 7'b1010101, 7'b1010101, 7'b0000000, 1'b1, 1);
        run_op("xor",     3'd5, 7'b1100000, 7'b0000011, 7'b1100011, 1'b0, 1);
        run_op("rol1",    3'd7, 7'b1000001, 7'b0000001, 7'b0000011, 1'b0, rot_lat(1));
        run_op("ror0",    3'd1, 7'b0110011, 7'b1111000, 7'b0110011, 1'b0, rot_lat(0));
        run_op("rol7",    3'd7, 7'b0110011, 7'b0000111, 7'b0110011, 1'b0, rot_lat(7));
        run_op("rol5",    3'd7, 7'b0000001, 7'b0000101, 7'b0100000, 1'b0, rot_lat(5));
        run_op("ror6",    3'd1, 7'b0000001, 7'b0000110, 7'b0000010, 1'b0, rot_lat(6));
        run_op("ror_z",   3'd1, 7'b0000000, 7'b0000010, 7'b0000000, 1'b1, rot_lat(2));

        // Back-pressure: response held for 4 cycles while a competing request is offered.
        cnt0 = ops_done;
        issue(3'd0, 7'b0000000, 7'b0000000);
        wait_rsp(n);
        req_valid = 1'b1; op = 3'd6; a = 7'b0001111; b = 7'b0000001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("stall_valid", 32'(rsp_valid), 32'd1);
            check_val("stall_res", 32'(result), 32'h7f);
            check_val("stall_flag", 32'(flag), 32'd0);
            check_val("stall_rdy", 32'(req_ready), 32'd0);
            check_val("stall_cnt", 32'(ops_done), 32'(cnt0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val("stall_release_cnt", 32'(ops_done), 32'(cnt0 + 8'd1));
        check_val("stall_release_rdy", 32'(req_ready), 32'd1);
        check_val("stall_release_valid", 32'(rsp_valid), 32'd0);

        // Reset two cycles into an op=7 amount-5 rotate abandons it.
        issue(3'd7, 7'b0000011, 7'b0000101);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_rst_rdy", 32'(req_ready), 32'd1);
        check_val("mid_rst_res", 32'(result), 32'd0);
        check_val("mid_rst_cnt", 32'(ops_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check_val("mid_rst_no_rsp", 32'(n), 32'd0);
        check_val("mid_rst_cnt_hold", 32'(ops_done), 32'd0);
        run_op("post_rst", 3'd0, 7'b0101010, 7'b0000000, 7'b1010101, 1'b0, 1);

        // 256 back-to-back AND transactions from a clean count.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op = 3'd3; a = 7'b1110001; b = 7'b0111011;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 700 && n < 256; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n++;
                if (n == 1 || n == 256) check_val("b2b_res", 32'(result), 32'b0110001);
                if (n == 256) begin
                    req_valid = 1'b0;
                    check_val("b2b_cnt255", 32'(ops_done), 32'd255);
                end
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("b2b_count", 32'(n), 32'd256);
        check_val("b2b_wrap", 32'(ops_done), 32'd0);
        check_val("b2b_idle", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
